aes_ctr_framer: RTL

Upstream framing stage for the iterative AES-256-CTR core. Per packet, it accepts a key/IV/direction descriptor on a sideband handshake and a 32-bit AXI-Stream payload. It emits the core's 128-bit input stream in this order:
- key low half, then key high half;
- initial counter block;
- payload packed into 128-bit blocks, with byte-accurate `tkeep` and `tlast` on the final block.

---
 rtl/aes_ctr_framer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_ctr_framer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : aes_ctr_framer                                                 |
// | Brief   : Frames key/IV/payload into the 128-bit AES-256-CTR core input. |
// |           Option macro: AES_FRAMER_ZERO_PAD_EN (zero unkept byte lanes). |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module aes_ctr_framer #(
  parameter int IN_WIDTH       = 32,
  parameter int AES_BLOCK_SIZE = 128
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          Cfg_valid,
  output logic                          Cfg_ready,
  input  logic [2*AES_BLOCK_SIZE-1:0]   Cfg_key,
  input  logic [AES_BLOCK_SIZE-1:0]     Cfg_iv,
  input  logic                          Cfg_encrypt,
  input  logic                          S_axis_tvalid,
  output logic                          S_axis_tready,
  input  logic [IN_WIDTH-1:0]           S_axis_tdata,
  input  logic [IN_WIDTH/8-1:0]         S_axis_tkeep,
  input  logic                          S_axis_tlast,
  output logic                          M_axis_tvalid,
  input  logic                          M_axis_tready,
  output logic [AES_BLOCK_SIZE-1:0]     M_axis_tdata,
  output logic [AES_BLOCK_SIZE/8-1:0]   M_axis_tkeep,
  output logic                          M_axis_tlast,
  output logic                          M_axis_tuser
);

  localparam int c_KW  = IN_WIDTH / 8;
  localparam int c_OKW = AES_BLOCK_SIZE / 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEY_LO = 3'd1,
    ST_KEY_HI = 3'd2,
    ST_IV     = 3'd3,
    ST_DATA   = 3'd4,
    ST_DRAIN  = 3'd5
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic                      r_m_tvalid, w_vld_nxt;
  logic [AES_BLOCK_SIZE-1:0] r_m_tdata, w_data_nxt;
  logic [c_OKW-1:0]          r_m_tkeep, w_keep_nxt;
  logic                      r_m_tlast, w_last_nxt;
  logic                      r_m_tuser, w_user_nxt;
  logic [AES_BLOCK_SIZE-1:0] r_key_hi, r_iv;
  logic                      r_enc;
  logic [AES_BLOCK_SIZE-1:0] r_pack, w_pack_nxt, w_pack_ins, w_data_blk;
  logic [c_OKW-1:0]          r_pk, w_pk_nxt, w_pk_ins, w_keep_blk, w_lane_mask;
  logic [1:0]                r_idx, w_idx_nxt;
  logic [6:0]                w_wbase;
  logic [3:0]                w_kbase;
  logic                      w_ld_cfg, w_m_hs, w_s_rdy, w_s_hs;

  assign w_m_hs  = r_m_tvalid & M_axis_tready;
  assign w_s_rdy = (r_state == ST_DATA) & (~r_m_tvalid | M_axis_tready);
  assign w_s_hs  = S_axis_tvalid & w_s_rdy;
  assign w_wbase = {r_idx, 5'd0};
  assign w_kbase = {r_idx, 2'b00};

  assign Cfg_ready     = (r_state == ST_IDLE);
  assign S_axis_tready = w_s_rdy;
  assign M_axis_tvalid = r_m_tvalid;
  assign M_axis_tdata  = r_m_tdata;
  assign M_axis_tkeep  = r_m_tkeep;
  assign M_axis_tlast  = r_m_tlast;
  assign M_axis_tuser  = r_m_tuser;

  // Block as it would look with the current word merged in; lanes above idx are stale.
  always_comb begin
    w_pack_ins = r_pack;
    w_pk_ins   = r_pk;
    w_pack_ins[w_wbase +: IN_WIDTH] = S_axis_tdata;
    w_pk_ins[w_kbase +: c_KW]       = S_axis_tkeep;
    case (r_idx)
      2'd0:    w_lane_mask = 16'h000F;
      2'd1:    w_lane_mask = 16'h00FF;
      2'd2:    w_lane_mask = 16'h0FFF;
      default: w_lane_mask = 16'hFFFF;
    endcase
    w_keep_blk = w_pk_ins & w_lane_mask;
    w_data_blk = w_pack_ins;
`ifdef AES_FRAMER_ZERO_PAD_EN
    for (int b = 0; b < c_OKW; b++) begin
      if (!w_keep_blk[b]) w_data_blk[8*b +: 8] = 8'h00;
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vld_nxt   = r_m_tvalid;
    w_data_nxt  = r_m_tdata;
    w_keep_nxt  = r_m_tkeep;
    w_last_nxt  = r_m_tlast;
    w_user_nxt  = r_m_tuser;
    w_idx_nxt   = r_idx;
    w_pack_nxt  = r_pack;
    w_pk_nxt    = r_pk;
    w_ld_cfg    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Cfg_valid) begin
          w_ld_cfg    = 1'b1;
          w_vld_nxt   = 1'b1;
          w_data_nxt  = Cfg_key[AES_BLOCK_SIZE-1:0];
          w_keep_nxt  = '1;
          w_last_nxt  = 1'b0;
          w_user_nxt  = Cfg_encrypt;
          w_state_nxt = ST_KEY_LO;
        end
      end
      ST_KEY_LO: begin
        if (w_m_hs) begin
          w_data_nxt  = r_key_hi;
          w_state_nxt = ST_KEY_HI;
        end
      end
      ST_KEY_HI: begin
        if (w_m_hs) begin
          w_data_nxt  = r_iv;
          w_state_nxt = ST_IV;
        end
      end
      ST_IV: begin
        if (w_m_hs) begin
          w_vld_nxt   = 1'b0;
          w_data_nxt  = '0;
          w_keep_nxt  = '0;
          w_last_nxt  = 1'b0;
          w_idx_nxt   = 2'd0;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_m_hs) w_vld_nxt = 1'b0;
        if (w_s_hs) begin
          w_pack_nxt = w_pack_ins;
          w_pk_nxt   = w_pk_ins;
          w_idx_nxt  = r_idx + 2'd1;
          if (r_idx == 2'd3 || S_axis_tlast) begin
            w_vld_nxt  = 1'b1;
            w_data_nxt = w_data_blk;
            w_keep_nxt = w_keep_blk;
            w_last_nxt = S_axis_tlast;
            w_idx_nxt  = 2'd0;
`ifdef AES_FRAMER_ZERO_PAD_EN
            w_pack_nxt = '0;
            w_pk_nxt   = '0;
`endif
          end
          if (S_axis_tlast) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_m_hs) begin
          w_vld_nxt = 1'b0;
          if (r_m_tlast) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= ST_IDLE;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 1'b0;
      r_key_hi   <= '0;
      r_iv       <= '0;
      r_enc      <= 1'b0;
      r_pack     <= '0;
      r_pk       <= '0;
      r_idx      <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_m_tvalid <= w_vld_nxt;
      r_m_tdata  <= w_data_nxt;
      r_m_tkeep  <= w_keep_nxt;
      r_m_tlast  <= w_last_nxt;
      r_m_tuser  <= w_user_nxt;
      r_pack     <= w_pack_nxt;
      r_pk       <= w_pk_nxt;
      r_idx      <= w_idx_nxt;
      if (w_ld_cfg) begin
        r_key_hi <= Cfg_key[2*AES_BLOCK_SIZE-1:AES_BLOCK_SIZE];
        r_iv     <= Cfg_iv;
        r_enc    <= Cfg_encrypt;
      end
    end
  end

endmodule
`default_nettype wire
